// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: control FSM for the iterative radix-2 Booth multiplier.
//
// Sequences operand load, one TEST/SHIFT pair per Booth iteration, and a
// one-cycle DONE. The 3-bit T-flip-flop iteration counter lives outside this
// block: it is cleared by cnt_clr, advanced by count_up, and its value is read
// back on count to spot the last iteration.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   start    in   request a new multiply (sampled in IDLE only)
//   q_lsb    in   Q[0] of the multiplier shift register
//   q_m1     in   Q[-1] Booth extension bit
//   count    in   iteration counter value (CNT_W bits)
//   abort    in   (BOOTH_ABORT_EN only) abandon the running operation
//   aborted  out  (BOOTH_ABORT_EN only) one-cycle pulse after an abort
//   count_up out  counter enable
//   cnt_clr  out  registered one-cycle counter clear
//   load     out  load operands, clear accumulator and Q[-1]
//   add      out  accumulator += multiplicand
//   sub      out  accumulator -= multiplicand
//   shift    out  arithmetic right shift of {A,Q,Q[-1]}
//   busy     out  high from LOAD through SHIFT
//   done     out  one-cycle completion pulse
//
// Optional feature: define BOOTH_ABORT_EN to add the abort/aborted ports.

module booth_seq_ctrl #(
  parameter int unsigned CNT_W  = 3,
  parameter int unsigned N_ITER = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             q_lsb,
  input  logic             q_m1,
  input  logic [CNT_W-1:0] count,
`ifdef BOOTH_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             count_up,
  output logic             cnt_clr,
  output logic             load,
  output logic             add,
  output logic             sub,
  output logic             shift,
  output logic             busy,
  output logic             done
);

  // Counter value seen during the final SHIFT (before its increment). With
  // N_ITER == 2**CNT_W the last increment simply wraps the counter to 0.
  localparam logic [CNT_W-1:0] LastCount = CNT_W'(N_ITER - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StTest, StShift, StDone} state_e;

  state_e state_q, state_d;
  logic   load_q, clr_q, shift_q, busy_q, done_q;
  logic   abort_act;
  logic   in_test;

`ifdef BOOTH_ABORT_EN
  logic aborted_q;
  // busy_q is high exactly in LOAD/TEST/SHIFT, the states an abort may cancel.
  assign abort_act = abort & busy_q;
  assign aborted   = aborted_q;
`else
  assign abort_act = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = StTest;
      StTest:  state_d = StShift;
      StShift: state_d = (count == LastCount) ? StDone : StTest;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_act) state_d = StIdle;
  end

  // State plus registered Moore outputs, all decoded from the next state so
  // they line up with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      load_q    <= 1'b0;
      clr_q     <= 1'b0;
      shift_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef BOOTH_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      load_q    <= (state_d == StLoad);
      clr_q     <= (state_d == StLoad);
      shift_q   <= (state_d == StShift);
      busy_q    <= (state_d == StLoad) || (state_d == StTest) || (state_d == StShift);
      done_q    <= (state_d == StDone);
`ifdef BOOTH_ABORT_EN
      aborted_q <= abort_act;
`endif
    end
  end

  // add/sub must see the Q bits of the current cycle (Q is loaded on the edge
  // that enters TEST), so they are decoded combinationally; pairs 10/01 are
  // mutually exclusive, so add and sub can never both be high.
  assign in_test  = (state_q == StTest) & ~abort_act;
  assign add      = in_test & ~q_lsb & q_m1;
  assign sub      = in_test & q_lsb & ~q_m1;
  assign shift    = shift_q & ~abort_act;
  assign count_up = shift_q & ~abort_act;
  assign load     = load_q;
  assign cnt_clr  = clr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Scoreboard bench for booth_seq_ctrl: a small Booth datapath and T-counter
// model are driven by the DUT's control outputs; expected per-cycle control
// vectors, products and latencies are queued at stimulus time and checked by
// an independent monitor.

module tb_booth_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, start;
  logic       q_lsb, q_m1;
  logic [2:0] count;
  logic       count_up, cnt_clr, load, add, sub, shift, busy, done;

  logic       start3;
  logic [2:0] count3;
  logic       count_up3, cnt_clr3, load3, add3, sub3, shift3, busy3, done3;

`ifdef BOOTH_ABORT_EN
  logic abort, aborted, aborted3;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int shifts = 0;
  int done_cnt = 0;
  int sh3 = 0;
  int st3 = 0;
  int done3_cnt = 0;
  logic [2:0] last3 = 3'd0;

  // {load, cnt_clr, add, sub, shift, count_up, busy, done}
  localparam logic [7:0] VLoad  = 8'b1100_0010;
  localparam logic [7:0] VTest  = 8'b0000_0010;
  localparam logic [7:0] VAdd   = 8'b0010_0010;
  localparam logic [7:0] VSub   = 8'b0001_0010;
  localparam logic [7:0] VShift = 8'b0000_1110;
  localparam logic [7:0] VDone  = 8'b0000_0001;

  logic [7:0]  exp_q[$];
  logic [15:0] prod_q[$];
  int          start_q[$];

  logic [7:0] outv;
  assign outv = {load, cnt_clr, add, sub, shift, count_up, busy, done};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  booth_seq_ctrl #(.CNT_W(3), .N_ITER(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .q_lsb    (q_lsb),
    .q_m1     (q_m1),
    .count    (count),
`ifdef BOOTH_ABORT_EN
    .abort    (abort),
    .aborted  (aborted),
`endif
    .count_up (count_up),
    .cnt_clr  (cnt_clr),
    .load     (load),
    .add      (add),
    .sub      (sub),
    .shift    (shift),
    .busy     (busy),
    .done     (done)
  );

  booth_seq_ctrl #(.CNT_W(3), .N_ITER(3)) dut3 (
    .clk      (clk),
    .reset    (reset),
    .start    (start3),
    .q_lsb    (1'b0),
    .q_m1     (1'b0),
    .count    (count3),
`ifdef BOOTH_ABORT_EN
    .abort    (1'b0),
    .aborted  (aborted3),
`endif
    .count_up (count_up3),
    .cnt_clr  (cnt_clr3),
    .load     (load3),
    .add      (add3),
    .sub      (sub3),
    .shift    (shift3),
    .busy     (busy3),
    .done     (done3)
  );

  // Counter models: no reset of their own, only the controller's clear.
  logic [2:0] cnt_m = 3'd0;
  logic [2:0] cnt3_m = 3'd0;
  always @(posedge clk) begin
    if (cnt_clr) cnt_m <= 3'd0;
    else if (count_up) cnt_m <= cnt_m + 3'd1;
    if (cnt_clr3) cnt3_m <= 3'd0;
    else if (count_up3) cnt3_m <= cnt3_m + 3'd1;
  end
  assign count  = cnt_m;
  assign count3 = cnt3_m;

  // Booth datapath model: {A,Q,Q[-1]}.
  logic [7:0] mplier = 8'd0, mcand = 8'd0;
  logic [7:0] a_m = 8'd0, q_m = 8'd0;
  logic       qm1_m = 1'b0;
  always @(posedge clk) begin
    if (load) begin
      a_m <= 8'd0; q_m <= mplier; qm1_m <= 1'b0;
    end else if (add) a_m <= a_m + mcand;
    else if (sub) a_m <= a_m - mcand;
    else if (shift) {a_m, q_m, qm1_m} <= {a_m[7], a_m, q_m};
  end
  assign q_lsb = q_m[0];
  assign q_m1  = qm1_m;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // acts: 2 bits per iteration, 0 none, 1 add, 2 sub (hand-derived from Q).
  task automatic push_run(input logic [15:0] acts);
    logic [1:0] a;
    exp_q.push_back(VLoad);
    for (int i = 0; i < 8; i++) begin
      a = acts[2*i +: 2];
      exp_q.push_back(a == 2'd1 ? VAdd : (a == 2'd2 ? VSub : VTest));
      exp_q.push_back(VShift);
    end
    exp_q.push_back(VDone);
  endtask

  task automatic issue(input logic [7:0] mp, input logic [7:0] mc, input logic [15:0] acts,
                       input logic [15:0] prod);
    mplier = mp;
    mcand  = mc;
    push_run(acts);
    prod_q.push_back(prod);
    start_q.push_back(cyc + 1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic flush();
    exp_q.delete();
    prod_q.delete();
    start_q.delete();
  endtask

  task automatic wait_done(input int budget);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1);
      if (done_cnt != d0) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got none want done within %0d cycles", budget);
    end
  endtask

  // Monitor for the 8-iteration instance.
  always @(negedge clk) begin
    logic [7:0] ev;
    if (!reset) begin
      if (outv != 8'h00) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL seq got %b want no_output", outv);
        end else begin
          ev = exp_q.pop_front();
          if (outv !== ev) begin
            errors++;
            $display("FAIL seq got %b want %b", outv, ev);
          end
        end
        if (load) shifts = 0;
        if (shift) shifts++;
      end
      if (done) begin
        done_cnt++;
        chk("shift_pulses", shifts, 8);
        chk("cnt_wrap", {29'd0, cnt_m}, 0);
        if (start_q.size() == 0 || prod_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got done want none");
        end else begin
          chk("latency", cyc + 1 - start_q.pop_front(), 18);
          chk("product", {16'd0, a_m, q_m}, {16'd0, prod_q.pop_front()});
        end
      end
    end
  end

  // Monitor for the 3-iteration instance.
  always @(negedge clk) begin
    if (!reset) begin
      if (load3) sh3 = 0;
      if (shift3) begin
        sh3++;
        last3 = cnt3_m;
      end
      if (done3) begin
        done3_cnt++;
        chk("n3_latency", cyc + 1 - st3, 8);
        chk("n3_shifts", sh3, 3);
        chk("n3_last_count", {29'd0, last3}, 2);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    reset  = 1'b1;
    start  = 1'b0;
    start3 = 1'b0;
`ifdef BOOTH_ABORT_EN
    abort  = 1'b0;
`endif
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("reset_outputs", {24'd0, outv}, 0);

    // Reset mid-operation with start held: outputs drop asynchronously.
    issue(8'd3, 8'hFE, 16'h0012, 16'hFFFA);
    tick(2);
    chk("busy_before_reset", {31'd0, busy}, 1);
    start = 1'b1;
    #2 reset = 1'b1;
    flush();
    #1 chk("async_reset_outputs", {24'd0, outv}, 0);
    tick(2);
    chk("held_reset_outputs", {24'd0, outv}, 0);
    reset = 1'b0;
    start = 1'b0;
    tick(4);
    chk("idle_after_reset", {24'd0, outv}, 0);
    chk("no_done_after_reset", done_cnt, 0);

    // 3 x -2: sub, none, add, then none.
    issue(8'd3, 8'hFE, 16'h0012, 16'hFFFA);
    wait_done(30);
    tick(3);

    // -3 x 5: sub, add, sub, then pairs of 11.
    issue(8'hFD, 8'd5, 16'h0026, 16'hFFF1);
    wait_done(30);
    tick(3);

    // 5 x 7 with extra start pulses mid-run: they must not queue a second run.
    d0 = done_cnt;
    issue(8'd5, 8'd7, 16'h0066, 16'h0023);
    tick(4);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(30);
    tick(10);
    chk("single_done", done_cnt - d0, 1);

    // Reset during the 4th SHIFT; the next run must clear the stale counter.
    d0 = done_cnt;
    issue(8'd3, 8'hFE, 16'h0012, 16'hFFFA);
    tick(8);
    chk("fourth_shift", {31'd0, shift}, 1);
    chk("count_at_fourth_shift", {29'd0, cnt_m}, 3);
    #2 reset = 1'b1;
    flush();
    #1 chk("reset_in_shift_outputs", {24'd0, outv}, 0);
    tick(1);
    reset = 1'b0;
    tick(4);
    chk("no_done_abandoned", done_cnt - d0, 0);
    issue(8'd3, 8'hFE, 16'h0012, 16'hFFFA);
    wait_done(30);
    tick(3);

`ifdef BOOTH_ABORT_EN
    // Q = 0000_0010: iteration 0 none, iteration 1 would subtract.
    d0 = done_cnt;
    mplier = 8'd2;
    mcand  = 8'd3;
    exp_q.push_back(VLoad);
    exp_q.push_back(VTest);
    exp_q.push_back(VShift);
    exp_q.push_back(VTest);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    abort = 1'b1;
    chk("abort_q_pair", {30'd0, q_lsb, q_m1}, 2);
    chk("abort_no_sub", {30'd0, add, sub}, 0);
    tick(1);
    abort = 1'b0;
    chk("abort_idle", {31'd0, busy}, 0);
    chk("aborted_pulse", {31'd0, aborted}, 1);
    tick(1);
    chk("aborted_single", {31'd0, aborted}, 0);
    tick(20);
    chk("abort_no_done", done_cnt - d0, 0);
`endif

    // N_ITER = 3 instance.
    st3 = cyc + 1;
    start3 = 1'b1;
    tick(1);
    start3 = 1'b0;
    for (int i = 0; i < 20 && done3_cnt == 0; i++) tick(1);
    chk("n3_done_seen", done3_cnt, 1);

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_seq_ctrl.md
Name: booth_seq_ctrl

Overview:
- Control FSM for the iterative radix-2 Booth multiplier datapath.
- Sequences operand load, the add/subtract/shift iterations, and completion.
- Drives the existing 3-bit T-flip-flop iteration counter through `count_up` and a clear pulse, and reads the counter value back to detect the last iteration.
- Sits between the top-level start/done handshake and the accumulator/shift-register datapath.

Parameters:
- CNT_W, 3, width of the iteration counter value read back. Must equal the counter width.
- N_ITER, 8, Booth iterations per operation. Legal range 1 to 2**CNT_W.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a new multiply. Sampled only in IDLE.
- q_lsb  input  1  Q[0] of the multiplier shift register
- q_m1  input  1  Q[-1] Booth extension bit
- count  input  CNT_W  current iteration counter value
- count_up  output  1  counter enable (T input)
- cnt_clr  output  1  registered one-cycle clear pulse to the counter
- load  output  1  load operands, clear accumulator and Q[-1]
- add  output  1  accumulator <= accumulator + multiplicand
- sub  output  1  accumulator <= accumulator - multiplicand
- shift  output  1  arithmetic right shift of {A,Q,Q[-1]}
- busy  output  1  high from LOAD through SHIFT
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, any time):
  - state goes to IDLE.
  - All outputs are 0, including cnt_clr, count_up and done.
  - A reset mid-operation abandons the operation with no done pulse.
- States and transitions:
  - IDLE: start=1 -> LOAD; otherwise remain.
  - LOAD: load=1, cnt_clr=1, busy=1 -> TEST.
  - TEST: busy=1 -> SHIFT.
    - {q_lsb,q_m1}=10 -> sub=1.
    - {q_lsb,q_m1}=01 -> add=1.
    - 00 or 11 -> neither.
  - SHIFT: shift=1, count_up=1, busy=1.
    - count==N_ITER-1 (value before this increment) -> DONE.
    - Otherwise -> TEST.
  - DONE: done=1, busy=0 -> IDLE.
- Output rules:
  - Outputs are Moore decodes of the registered state.
  - add/sub additionally depend on q_lsb/q_m1, sampled in TEST only.
  - add and sub are never both 1.
  - cnt_clr comes from a flop so it is glitch-free. The integration derives the counter's clear from cnt_clr.
- Latency: start sampled at edge k -> load in cycle k+1 -> done in cycle k+2+2*N_ITER. For N_ITER=8, done is 18 cycles after the start edge.
- Start handling:
  - start while busy or in DONE is ignored, not queued.
  - start held continuously re-triggers LOAD on the cycle after DONE.
- Counter wrap: with N_ITER=2**CNT_W, the final count_up wraps the counter to 0; no special handling is needed.
- Counter independence: the controller never relies on the counter value outside SHIFT.

Optional Feature:
- Macro: BOOTH_ABORT_EN.
- When defined:
  - Adds input `abort` (1 bit) and output `aborted` (1 bit, reset 0).
  - abort=1 in LOAD, TEST or SHIFT -> next state IDLE.
  - In that same cycle the datapath outputs are forced to 0: no add, sub, shift or count_up.
  - aborted pulses 1 for one cycle after the transition; done is not asserted.
  - abort in IDLE or DONE has no effect; DONE completes normally.
- When undefined: no abort or aborted ports, and the behaviour is exactly as above.

Test Plan:
- Reset values: assert reset mid-cycle with start=1 -> all outputs 0 asynchronously; state IDLE after release; no done.
- Multiply 3 x -2, N_ITER=8, q bit pairs from a model of Q = 0000_0011:
  - Sequence is load, sub, shift, (none), shift, add, shift, then (none)/shift for the rest.
  - Exactly 8 shift and 8 count_up pulses.
  - done at cycle 18; counter reads 0 afterwards.
- start pulsed at cycles 5 and 10 after a start at cycle 0 -> only one LOAD; single done at cycle 18.
- reset asserted during the 4th SHIFT -> outputs 0 immediately; no done. A new start afterwards -> cnt_clr pulse, then a full 8-iteration run.
- N_ITER=3, CNT_W=3 -> 3 iterations; done 8 cycles after the start edge; DONE entered when count==2.
- With BOOTH_ABORT_EN: abort during the 2nd TEST -> that cycle has no add/sub; IDLE next cycle; aborted pulses once; done stays 0.
